etapa_if_id_ctrl: RTL and testbench

Next-generation IF/ID pipeline register for the MIPS core, parametrised in data and PC width. Adds flush-to-bubble, a valid bit, and selectable debug stepping: continuous-gate mode, or single-step on the rising edge of i_Step. Adds saturating stall/flush event counters that the debug unit reads. Sits between instruction fetch and decode, and is controlled by the hazard unit (write enable, flush) and the debug unit (step, mode, counter clear).

---
 rtl/etapa_if_id_ctrl_pkg.sv | 28 ++
 rtl/etapa_if_id_ctrl_step_edge_gen.sv | 29 ++
 rtl/etapa_if_id_ctrl.sv | 118 +++++++++++
 tb/tb_etapa_if_id_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/etapa_if_id_ctrl_pkg.sv
// Shared definitions for the pipeline stage registers (IF/ID and its successors).
//   STEP_CONT / STEP_SINGLE : debug step-mode encodings for i_StepMode
//   NOP_WORD                : default bubble instruction word
//   adv_act_e / f_action    : per-cycle action of a stage register when enabled
package etapa_if_id_ctrl_pkg;

   localparam logic STEP_CONT   = 1'b0;
   localparam logic STEP_SINGLE = 1'b1;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      ActIdle,
      ActLoad,
      ActStall,
      ActFlush
   } adv_act_e;

   // Flush beats stall beats load; nothing happens unless the stage is enabled.
   function automatic adv_act_e f_action(input logic adv_en, input logic flush,
                                         input logic write);
      if (!adv_en)     return ActIdle;
      else if (flush)  return ActFlush;
      else if (!write) return ActStall;
      else             return ActLoad;
   endfunction

endpackage

// File: rtl/etapa_if_id_ctrl_step_edge_gen.sv
// Debug step gate shared by the stage registers.
//   i_clk, i_reset (sync, active-low)
//   i_Step     : debug run/step input
//   i_StepMode : STEP_CONT = advance while i_Step=1, STEP_SINGLE = advance on rising edge
//   o_AdvEn    : stage enable for this cycle
module step_edge_gen
   import etapa_if_id_ctrl_pkg::*;
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_Step,
   input  logic i_StepMode,
   output logic o_AdvEn
);

   logic r_step_q;

   // Tracked in both modes so a mode switch with i_Step high sees no fake edge.
   always_ff @(posedge i_clk) begin
      if (!i_reset) r_step_q <= 1'b0;
      else          r_step_q <= i_Step;
   end

   always_comb begin
      o_AdvEn = i_Step;
      if (i_StepMode == STEP_SINGLE) o_AdvEn = i_Step & ~r_step_q;
   end

endmodule

// File: rtl/etapa_if_id_ctrl.sv
// IF/ID pipeline register with flush-to-bubble, valid bit, debug stepping and
// saturating stall/flush event counters.
//   i_clk, i_reset (sync, active-low)
//   i_Step, i_StepMode           : debug step control
//   i_IF_ID_Write, i_IF_ID_Flush : hazard-unit stall / flush
//   i_Valid, i_PC4, i_PC8, i_Instruction : fetch outputs
//   i_CntClear                   : zero both event counters
//   o_PC4, o_PC8, o_Instruction, o_Valid : registered fetch fields
//   o_Advance                    : pulse the cycle after a load or flush
//   o_StallCount, o_FlushCount   : saturating event counters
module etapa_if_id_ctrl
   import etapa_if_id_ctrl_pkg::*;
#(
   parameter int unsigned       NBITS  = 32,
   parameter int unsigned       PCBITS = 32,
   parameter logic [NBITS-1:0]  NOP    = {NBITS{1'b0}},
   parameter int unsigned       CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_Step,
   input  logic              i_StepMode,
   input  logic              i_IF_ID_Write,
   input  logic              i_IF_ID_Flush,
   input  logic              i_Valid,
   input  logic              i_CntClear,
   input  logic [PCBITS-1:0] i_PC4,
   input  logic [PCBITS-1:0] i_PC8,
   input  logic [NBITS-1:0]  i_Instruction,
   output logic [PCBITS-1:0] o_PC4,
   output logic [PCBITS-1:0] o_PC8,
   output logic [NBITS-1:0]  o_Instruction,
   output logic              o_Valid,
   output logic              o_Advance,
   output logic [CNT_W-1:0]  o_StallCount,
   output logic [CNT_W-1:0]  o_FlushCount
);

   logic              w_adv_en;
   adv_act_e          w_act;
   logic [CNT_W-1:0]  w_stall_cnt_d;
   logic [CNT_W-1:0]  w_flush_cnt_d;

   logic [PCBITS-1:0] r_pc4;
   logic [PCBITS-1:0] r_pc8;
   logic [NBITS-1:0]  r_instr;
   logic              r_valid;
   logic              r_advance;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   step_edge_gen u_step_edge_gen (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_Step     (i_Step),
      .i_StepMode (i_StepMode),
      .o_AdvEn    (w_adv_en)
   );

   always_comb begin
      w_act = f_action(w_adv_en, i_IF_ID_Flush, i_IF_ID_Write);
   end

   // Saturate at all-ones; a clear overrides a same-cycle increment.
   always_comb begin
      w_stall_cnt_d = r_stall_cnt;
      w_flush_cnt_d = r_flush_cnt;
      if (i_CntClear) begin
         w_stall_cnt_d = '0;
         w_flush_cnt_d = '0;
      end else begin
         if ((w_act == ActStall) && (r_stall_cnt != {CNT_W{1'b1}}))
            w_stall_cnt_d = r_stall_cnt + CNT_W'(1);
         if ((w_act == ActFlush) && (r_flush_cnt != {CNT_W{1'b1}}))
            w_flush_cnt_d = r_flush_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_pc4       <= '0;
         r_pc8       <= '0;
         r_instr     <= NOP;
         r_valid     <= 1'b0;
         r_advance   <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         unique case (w_act)
            ActFlush: begin
               r_pc4   <= '0;
               r_pc8   <= '0;
               r_instr <= NOP;
               r_valid <= 1'b0;
            end
            ActLoad: begin
               r_pc4   <= i_PC4;
               r_pc8   <= i_PC8;
               r_instr <= i_Instruction;
               r_valid <= i_Valid;
            end
            default: ; // idle and stall hold the data path
         endcase
         r_advance   <= (w_act == ActFlush) || (w_act == ActLoad);
         r_stall_cnt <= w_stall_cnt_d;
         r_flush_cnt <= w_flush_cnt_d;
      end
   end

   assign o_PC4         = r_pc4;
   assign o_PC8         = r_pc8;
   assign o_Instruction = r_instr;
   assign o_Valid       = r_valid;
   assign o_Advance     = r_advance;
   assign o_StallCount  = r_stall_cnt;
   assign o_FlushCount  = r_flush_cnt;

endmodule

// File: tb/tb_etapa_if_id_ctrl.sv
// Bench for etapa_if_id_ctrl: a 16-bit-counter instance and a 4-bit-counter
// instance share all inputs and are compared against a cycle reference model.
module tb_etapa_if_id_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        step = 1'b0, mode = 1'b0, wr = 1'b0, fl = 1'b0, val = 1'b0, clr = 1'b0;
   logic [31:0] pc4 = '0, pc8 = '0, ins = '0;

   logic [31:0] o_pc4, o_pc8, o_ins, o4_pc4, o4_pc8, o4_ins;
   logic        o_val, o_adv, o4_val, o4_adv;
   logic [15:0] o_sc, o_fc;
   logic [3:0]  o4_sc, o4_fc;

   always #5 clk = ~clk;

   etapa_if_id_ctrl u_dut (
      .i_clk(clk), .i_reset(rst), .i_Step(step), .i_StepMode(mode),
      .i_IF_ID_Write(wr), .i_IF_ID_Flush(fl), .i_Valid(val), .i_CntClear(clr),
      .i_PC4(pc4), .i_PC8(pc8), .i_Instruction(ins),
      .o_PC4(o_pc4), .o_PC8(o_pc8), .o_Instruction(o_ins), .o_Valid(o_val),
      .o_Advance(o_adv), .o_StallCount(o_sc), .o_FlushCount(o_fc)
   );

   etapa_if_id_ctrl #(.CNT_W(4)) u_dut4 (
      .i_clk(clk), .i_reset(rst), .i_Step(step), .i_StepMode(mode),
      .i_IF_ID_Write(wr), .i_IF_ID_Flush(fl), .i_Valid(val), .i_CntClear(clr),
      .i_PC4(pc4), .i_PC8(pc8), .i_Instruction(ins),
      .o_PC4(o4_pc4), .o_PC8(o4_pc8), .o_Instruction(o4_ins), .o_Valid(o4_val),
      .o_Advance(o4_adv), .o_StallCount(o4_sc), .o_FlushCount(o4_fc)
   );

   wire [129:0] w_got = {o_pc4, o_pc8, o_ins, o_val, o_adv, o_sc, o_fc};
   wire [105:0] w_got4 = {o4_pc4, o4_pc8, o4_ins, o4_val, o4_adv, o4_sc, o4_fc};

   int n_chk = 0;
   int n_err = 0;

   // Reference model: raw event counts since the last clear, saturated on readout.
   logic [31:0] m_pc4 = '0, m_pc8 = '0, m_ins = '0;
   logic        m_val = 1'b0, m_adv = 1'b0, m_prev = 1'b0;
   int          m_stalls = 0, m_flushes = 0;

   function automatic int sat(input int raw, input int maxv);
      return (raw > maxv) ? maxv : raw;
   endfunction

   function automatic logic [129:0] exp_vec();
      return {m_pc4, m_pc8, m_ins, m_val, m_adv,
              16'(sat(m_stalls, 65535)), 16'(sat(m_flushes, 65535))};
   endfunction

   function automatic logic [105:0] exp_vec4();
      return {m_pc4, m_pc8, m_ins, m_val, m_adv,
              4'(sat(m_stalls, 15)), 4'(sat(m_flushes, 15))};
   endfunction

   // Advance the model by the current inputs, then clock the DUTs.
   task automatic tick();
      bit adv;
      if (!rst) begin
         m_pc4 = '0; m_pc8 = '0; m_ins = '0; m_val = 1'b0; m_adv = 1'b0;
         m_prev = 1'b0; m_stalls = 0; m_flushes = 0;
      end else begin
         adv    = mode ? (step && !m_prev) : step;
         m_prev = step;
         m_adv  = adv && (fl || wr);
         if (adv) begin
            if (fl) begin
               m_pc4 = '0; m_pc8 = '0; m_ins = '0; m_val = 1'b0; m_flushes++;
            end else if (!wr) begin
               m_stalls++;
            end else begin
               m_pc4 = pc4; m_pc8 = pc8; m_ins = ins; m_val = val;
            end
         end
         if (clr) begin
            m_stalls = 0; m_flushes = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; step = 1; mode = 1; wr = 1; fl = 1; val = 1; clr = 1;
      pc4 = '1; pc8 = '1; ins = '1;
      tick();
      n_chk++;
      if (w_got !== exp_vec() || w_got4 !== exp_vec4()) begin
         n_err++; $display("FAIL reset_model: got %h/%h exp %h/%h", w_got, w_got4, exp_vec(), exp_vec4());
      end
      n_chk++;
      if ({o_pc4, o_pc8, o_ins, o_val, o_adv, o_sc, o_fc} !== 130'd0) begin
         n_err++; $display("FAIL reset_zero: got %h exp 0", w_got);
      end
      rst = 1'b1; mode = 0; step = 1; wr = 1; fl = 0; clr = 0; val = 1;
      ins = 32'h8C22_0004; pc4 = 32'd4; pc8 = 32'd8;
      tick();
      n_chk++;
      if (o_ins !== 32'h8C22_0004 || o_pc4 !== 32'd4 || o_val !== 1'b1 || o_adv !== 1'b1) begin
         n_err++; $display("FAIL first_load: got ins=%h pc4=%0d v=%b a=%b exp ins=8c220004 pc4=4 v=1 a=1",
                           o_ins, o_pc4, o_val, o_adv);
      end
   endtask

   task automatic test_stall_flush();
      wr = 0;
      for (int i = 0; i < 3; i++) begin
         ins = $urandom; pc4 = $urandom; pc8 = $urandom;
         tick();
         n_chk++;
         if (w_got !== exp_vec() || o_adv !== 1'b0) begin
            n_err++; $display("FAIL stall_hold: got %h exp %h", w_got, exp_vec());
         end
      end
      n_chk++;
      if (o_sc !== 16'd3 || o_ins !== 32'h8C22_0004) begin
         n_err++; $display("FAIL stall_count: got sc=%0d ins=%h exp sc=3 ins=8c220004", o_sc, o_ins);
      end
      fl = 1;
      tick();
      n_chk++;
      if (o_ins !== 32'd0 || o_val !== 1'b0 || o_fc !== 16'd1 || o_adv !== 1'b1
          || w_got !== exp_vec()) begin
         n_err++; $display("FAIL flush: got %h exp %h", w_got, exp_vec());
      end
      fl = 0;
   endtask

   task automatic test_single_step();
      int          advs;
      logic [31:0] first;
      mode = 1; wr = 1; step = 0; val = 1;
      tick();
      step = 1; advs = 0; first = 32'h1111_0001;
      for (int i = 0; i < 5; i++) begin
         ins = first + 32'(i); pc4 = 32'(100 + i);
         tick();
         advs += int'(o_adv);
         n_chk++;
         if (w_got !== exp_vec()) begin
            n_err++; $display("FAIL step_hold: got %h exp %h", w_got, exp_vec());
         end
      end
      n_chk++;
      if (advs != 1 || o_ins !== first) begin
         n_err++; $display("FAIL single_once: got advances=%0d ins=%h exp 1 %h", advs, o_ins, first);
      end
      step = 0;
      tick();
      step = 1; ins = 32'h2222_0002;
      tick();
      n_chk++;
      if (o_ins !== 32'h2222_0002 || o_adv !== 1'b1) begin
         n_err++; $display("FAIL second_step: got ins=%h a=%b exp 22220002 1", o_ins, o_adv);
      end
      step = 0; fl = 1;
      tick();
      n_chk++;
      if (o_ins !== 32'h2222_0002 || o_val !== 1'b1 || o_adv !== 1'b0 || w_got !== exp_vec()) begin
         n_err++; $display("FAIL flush_ignored: got %h exp %h", w_got, exp_vec());
      end
      fl = 0;
      tick();
   endtask

   task automatic test_mode_switch();
      int advs;
      mode = 0; step = 1; wr = 1; ins = 32'h3333_0003;
      tick();
      mode = 1; advs = 0;
      for (int i = 0; i < 4; i++) begin
         ins = 32'h4444_0000 + 32'(i);
         tick();
         advs += int'(o_adv);
      end
      n_chk++;
      if (advs != 0 || o_ins !== 32'h3333_0003 || w_got !== exp_vec()) begin
         n_err++; $display("FAIL mode_switch_quiet: got advances=%0d ins=%h exp 0 33330003", advs, o_ins);
      end
      step = 0;
      tick();
      step = 1; ins = 32'h5555_0005;
      tick();
      n_chk++;
      if (o_adv !== 1'b1 || o_ins !== 32'h5555_0005) begin
         n_err++; $display("FAIL mode_switch_edge: got a=%b ins=%h exp 1 55550005", o_adv, o_ins);
      end
   endtask

   task automatic test_saturation();
      mode = 0; step = 1; wr = 0; fl = 0; clr = 1;
      tick();
      n_chk++;
      if (o_sc !== 16'd0 || o4_sc !== 4'd0) begin
         n_err++; $display("FAIL clear_wins: got %0d/%0d exp 0/0", o_sc, o4_sc);
      end
      clr = 0;
      for (int i = 0; i < 20; i++) tick();
      n_chk++;
      if (o4_sc !== 4'd15 || o_sc !== 16'd20 || w_got4 !== exp_vec4()) begin
         n_err++; $display("FAIL saturate: got %0d/%0d exp 20/15", o_sc, o4_sc);
      end
      clr = 1;
      tick();
      n_chk++;
      if (o_sc !== 16'd0 || o4_sc !== 4'd0 || o_fc !== 16'd0 || w_got !== exp_vec()) begin
         n_err++; $display("FAIL clear_stall: got sc=%0d/%0d fc=%0d exp 0", o_sc, o4_sc, o_fc);
      end
      clr = 0;
   endtask

   task automatic test_mid_reset();
      mode = 1; wr = 1; step = 0;
      tick();
      step = 1; ins = 32'h6666_0006; val = 1;
      tick();
      rst = 0;
      tick();
      n_chk++;
      if (w_got !== 130'd0 || w_got4 !== exp_vec4()) begin
         n_err++; $display("FAIL mid_reset: got %h exp 0", w_got);
      end
      rst = 1; ins = 32'h7777_0007;
      tick();
      n_chk++;
      if (o_adv !== 1'b1 || o_ins !== 32'h7777_0007 || w_got !== exp_vec()) begin
         n_err++; $display("FAIL post_reset_step: got a=%b ins=%h exp 1 77770007", o_adv, o_ins);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst  = ($urandom % 60) != 0;
         step = ($urandom % 4) != 0;
         if (($urandom % 10) == 0) mode = ~mode;
         wr   = ($urandom % 4) != 0;
         fl   = ($urandom % 6) == 0;
         val  = $urandom % 2;
         clr  = ($urandom % 50) == 0;
         pc4  = $urandom; pc8 = $urandom; ins = $urandom;
         tick();
         n_chk++;
         if (w_got !== exp_vec() || w_got4 !== exp_vec4()) begin
            n_err++; $display("FAIL random[%0d]: got %h/%h exp %h/%h", i, w_got, w_got4,
                              exp_vec(), exp_vec4());
         end
      end
   endtask

   initial begin
      test_reset();
      test_stall_flush();
      test_single_step();
      test_mode_switch();
      test_saturation();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
